// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the CPU MEM stage, the debug requester, the data SRAM and
// dmem_port_arbiter. The arbiter uses the slave view; the environment the master view.
interface dmem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_gnt;
   logic              dbg_rvalid;
   logic [DATA_W-1:0] dbg_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_stall, cpu_rvalid, cpu_rdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_gnt, dbg_rvalid, dbg_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_stall, cpu_rvalid, cpu_rdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_gnt, dbg_rvalid, dbg_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-SRAM port between the CPU MEM stage and a debug requester.
// Define DMEM_ARB_PERF_EN to add saturating stall / forced-debug-grant counters.
module dmem_port_arbiter #(
   parameter int unsigned ADDR_W     = 11,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic               clk,
   input  logic               reset,
`ifdef DMEM_ARB_PERF_EN
   output logic [15:0]        perf_cpu_wait,
   output logic [7:0]         perf_dbg_force,
`endif
   dmem_port_arbiter_if.slave bus
);

   localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
   localparam int unsigned LatW    = 2;
   localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);
   localparam logic [LatW-1:0]    LatInit   = LatW'(RD_LAT - 1);

   typedef enum logic [1:0] {StIdle, StWaitRd, StResp} state_e;

   state_e              state_q;
   logic [LatW-1:0]     lat_q;
   logic                owner_dbg_q;
   logic [StarveW-1:0]  starve_q;
   logic                cpu_rvalid_q;
   logic                dbg_rvalid_q;
   logic [DATA_W-1:0]   cpu_rdata_q;
   logic [DATA_W-1:0]   dbg_rdata_q;

   logic                dbg_win;
   logic                cpu_win;
   logic                issue_rd;
   logic                cpu_stall;

   // Debug only beats a live CPU request once the CPU has won STARVE_MAX times in a row.
   always_comb begin
      dbg_win = 1'b0;
      cpu_win = 1'b0;
      if (state_q == StIdle && !reset) begin
         if (bus.dbg_req && (!bus.cpu_req || starve_q == StarveMax)) begin
            dbg_win = 1'b1;
         end else if (bus.cpu_req) begin
            cpu_win = 1'b1;
         end
      end
   end

   always_comb begin
      bus.mem_en    = dbg_win | cpu_win;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (dbg_win) begin
         bus.mem_we    = bus.dbg_we;
         bus.mem_addr  = bus.dbg_addr;
         bus.mem_wdata = bus.dbg_wdata;
      end else if (cpu_win) begin
         bus.mem_we    = bus.cpu_we;
         bus.mem_addr  = bus.cpu_addr;
         bus.mem_wdata = bus.cpu_wdata;
      end
   end

   assign issue_rd = bus.mem_en & ~bus.mem_we;

   // A CPU read releases the pipeline in its response cycle, a write in its issue cycle.
   assign cpu_stall      = bus.cpu_req & ~((cpu_win & bus.cpu_we) | cpu_rvalid_q);
   assign bus.cpu_stall  = cpu_stall;
   assign bus.cpu_rvalid = cpu_rvalid_q;
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.dbg_gnt    = dbg_win;
   assign bus.dbg_rvalid = dbg_rvalid_q;
   assign bus.dbg_rdata  = dbg_rdata_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         lat_q        <= '0;
         owner_dbg_q  <= 1'b0;
         starve_q     <= '0;
         cpu_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         cpu_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;

         if (dbg_win || !bus.dbg_req) begin
            starve_q <= '0;
         end else if (cpu_win && starve_q != StarveMax) begin
            starve_q <= starve_q + 1'b1;
         end

         unique case (state_q)
            StIdle: begin
               if (issue_rd) begin
                  state_q     <= StWaitRd;
                  lat_q       <= LatInit;
                  owner_dbg_q <= dbg_win;
               end
            end
            StWaitRd: begin
               if (lat_q == '0) begin
                  state_q <= StResp;
                  if (owner_dbg_q) begin
                     dbg_rdata_q  <= bus.mem_rdata;
                     dbg_rvalid_q <= 1'b1;
                  end else begin
                     cpu_rdata_q  <= bus.mem_rdata;
                     cpu_rvalid_q <= 1'b1;
                  end
               end else begin
                  lat_q <= lat_q - 1'b1;
               end
            end
            StResp:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef DMEM_ARB_PERF_EN
   // A debug win against a live CPU request can only come from starvation.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_cpu_wait  <= '0;
         perf_dbg_force <= '0;
      end else begin
         if (cpu_stall && perf_cpu_wait != 16'hFFFF) begin
            perf_cpu_wait <= perf_cpu_wait + 16'd1;
         end
         if (dbg_win && bus.cpu_req && perf_dbg_force != 8'hFF) begin
            perf_dbg_force <= perf_dbg_force + 8'd1;
         end
      end
   end
`else
   // No performance counters in this build.
`endif

   a_cpu_addr_held : assert property (@(posedge clk)
      (!reset && cpu_stall) |=> (reset || (bus.cpu_req && $stable(bus.cpu_addr))))
      else $error("cpu_addr changed while the MEM stage was stalled");

endmodule
